// File: rtl/fetch_aligner.sv
// fetch_aligner: halfword-granular instruction buffer between fetch and decode.
// It reassembles 16/32-bit instructions from FETCH_W-bit fetch words, including
// 32-bit instructions that straddle two words, and restarts on a redirect.
//
// Configuration macro: FETCH_ALIGN_RVC_EN
//   defined   - 16-bit compressed instructions are recognised; redirect
//               targets may have pc[1] = 1.
//   undefined - every instruction is 32 bits; pc[1] of a redirect target is
//               ignored; o_instr_c is tied low.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_flush, i_flush_pc   redirect request and target PC (bit 0 ignored)
//   i_fetch_valid/_data   incoming fetch word, lowest halfword at lowest address
//   o_fetch_ready         room for a whole fetch word
//   o_instr_valid/_ready  decode handshake
//   o_instr, o_instr_pc   head instruction (compressed ones zero-extended) and PC
//   o_instr_c             head instruction is 16-bit
module fetch_aligner #(
    parameter int unsigned FETCH_W  = 32,
    parameter int unsigned DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_flush,
    input  logic [31:0]        i_flush_pc,
    input  logic               i_fetch_valid,
    input  logic [FETCH_W-1:0] i_fetch_data,
    output logic               o_fetch_ready,
    output logic               o_instr_valid,
    output logic [31:0]        o_instr,
    output logic [31:0]        o_instr_pc,
    output logic               o_instr_c,
    input  logic               i_instr_ready
);

    localparam int unsigned HW_PER_W = FETCH_W / 16;
    localparam int unsigned PTR_W    = $clog2(DEPTH);
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam int unsigned SKIP_W   = $clog2(HW_PER_W);

    logic [15:0]        mem_q [DEPTH];
    logic [15:0]        mem_d [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [31:0]        pc_q, pc_d;
    logic [SKIP_W-1:0]  skip_q, skip_d;

    logic [15:0]        hw0, hw1;
    logic               head_32;
    logic [CNT_W-1:0]   head_need;
    logic [CNT_W-1:0]   free_hw;
    logic [CNT_W-1:0]   push_hw;
    logic [CNT_W-1:0]   pop_hw;
    logic               push;
    logic               pop;
    logic               instr_valid;
    logic [31:0]        flush_pc_eff;

    // Head halfwords; the second one is only meaningful for a 32-bit head.
    assign hw0 = mem_q[rd_ptr_q];
    assign hw1 = mem_q[rd_ptr_q + PTR_W'(1)];

`ifdef FETCH_ALIGN_RVC_EN
    assign head_32      = (hw0[1:0] == 2'b11);
    assign flush_pc_eff = i_flush_pc & 32'hFFFF_FFFE;
`else
    assign head_32      = 1'b1;
    assign flush_pc_eff = i_flush_pc & 32'hFFFF_FFFC;
`endif

    assign head_need = head_32 ? CNT_W'(2) : CNT_W'(1);
    assign free_hw   = CNT_W'(DEPTH) - count_q;

    // Written so an empty buffer never depends on the (unreset) storage contents.
    assign instr_valid = !i_flush &&
                         ((count_q >= CNT_W'(2)) || ((count_q == CNT_W'(1)) && !head_32));

    assign o_fetch_ready = !i_flush && (free_hw >= CNT_W'(HW_PER_W));
    assign o_instr_valid = instr_valid;
    assign o_instr       = !instr_valid ? 32'h0000_0000 :
                           head_32      ? {hw1, hw0} : {16'h0000, hw0};
    assign o_instr_c     = instr_valid && !head_32;
    assign o_instr_pc    = pc_q;

    assign push    = i_fetch_valid && o_fetch_ready;
    assign pop     = instr_valid && i_instr_ready;
    assign push_hw = push ? (CNT_W'(HW_PER_W) - CNT_W'(skip_q)) : '0;
    assign pop_hw  = pop ? head_need : '0;

    // Next-state: redirect wins over push/pop; otherwise both may apply together.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        pc_d     = pc_q;
        skip_d   = skip_q;
        if (i_flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            pc_d     = flush_pc_eff;
            skip_d   = flush_pc_eff[SKIP_W:1];
        end else begin
            if (push) begin
                // Halfwords below the redirect target are dropped, the rest packed from wr_ptr.
                for (int h = 0; h < int'(HW_PER_W); h++) begin
                    if (SKIP_W'(h) >= skip_q) begin
                        mem_d[wr_ptr_q + PTR_W'(h) - PTR_W'(skip_q)] = i_fetch_data[h*16 +: 16];
                    end
                end
                wr_ptr_d = wr_ptr_q + PTR_W'(push_hw);
                skip_d   = '0;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(head_need);
                pc_d     = pc_q + (head_32 ? 32'd4 : 32'd2);
            end
            count_d = count_q + push_hw - pop_hw;
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            pc_q     <= RESET_PC;
            skip_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            pc_q     <= pc_d;
            skip_q   <= skip_d;
        end
    end

    // Halfword storage is not reset; count gates every read of it.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: tb/tb_fetch_aligner.sv
// Directed bench for fetch_aligner (FETCH_W = 32, DEPTH = 8). Works in both
// builds; compressed-instruction sequences only run with FETCH_ALIGN_RVC_EN.
module tb_fetch_aligner;

    localparam int unsigned FETCH_W  = 32;
    localparam int unsigned DEPTH    = 8;
    localparam logic [31:0] RP       = 32'h0000_0040;

`ifdef FETCH_ALIGN_RVC_EN
    localparam logic [31:0] FL1_PC  = 32'h0000_0102;
    localparam logic [31:0] FL2_PC  = 32'h0000_0206;
    localparam logic [31:0] G_INSTR = 32'h0000_AAAA;
    localparam logic        G_C     = 1'b1;
`else
    localparam logic [31:0] FL1_PC  = 32'h0000_0100;
    localparam logic [31:0] FL2_PC  = 32'h0000_0204;
    localparam logic [31:0] G_INSTR = 32'hAAAA_4505;
    localparam logic        G_C     = 1'b0;
`endif

    logic               clk;
    logic               rst;
    logic               flush;
    logic [31:0]        flush_pc;
    logic               fv;
    logic [FETCH_W-1:0] fdata;
    logic               fr;
    logic               iv;
    logic [31:0]        instr;
    logic [31:0]        ipc;
    logic               ic;
    logic               ir;

    int total = 0;
    int bad   = 0;

    fetch_aligner #(
        .FETCH_W  (FETCH_W),
        .DEPTH    (DEPTH),
        .RESET_PC (RP)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_flush       (flush),
        .i_flush_pc    (flush_pc),
        .i_fetch_valid (fv),
        .i_fetch_data  (fdata),
        .o_fetch_ready (fr),
        .o_instr_valid (iv),
        .o_instr       (instr),
        .o_instr_pc    (ipc),
        .o_instr_c     (ic),
        .i_instr_ready (ir)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        fl;
        logic [31:0] fpc;
        logic        fv;
        logic [31:0] fd;
        logic        rdy;
        logic        chk;
        logic        e_fr;
        logic        e_v;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic        e_c;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic f, input logic [31:0] fp,
                                input logic v, input logic [31:0] d, input logic rd,
                                input logic c, input logic efr, input logic ev,
                                input logic [31:0] ei, input logic [31:0] ep, input logic ec);
        vec_t x;
        x.rst = r;  x.fl = f;  x.fpc = fp; x.fv = v; x.fd = d; x.rdy = rd; x.chk = c;
        x.e_fr = efr; x.e_v = ev; x.e_instr = ei; x.e_pc = ep; x.e_c = ec;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic efr, input logic ev,
                             input logic [31:0] ei, input logic [31:0] ep, input logic ec);
        check({tag, ".ready"}, 32'(fr), 32'(efr));
        check({tag, ".valid"}, 32'(iv), 32'(ev));
        check({tag, ".instr"}, instr, ei);
        check({tag, ".pc"},    ipc, ep);
        check({tag, ".c"},     32'(ic), 32'(ec));
    endtask

    // One cycle: drive at the falling edge, let outputs settle, sample before the rising edge.
    task automatic step(input logic r, input logic f, input logic [31:0] fp,
                        input logic v, input logic [31:0] d, input logic rd);
        @(negedge clk);
        rst = r; flush = f; flush_pc = fp; fv = v; fdata = d; ir = rd;
        #1;
    endtask

    task automatic wait_valid(input int budget, input string name);
        int n = 0;
        while (!iv && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        total++;
        if (!iv) begin
            bad++;
            $display("FAIL %s: o_instr_valid still 0 after %0d cycles", name, budget);
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; flush_pc = '0; fv = 1'b0; fdata = '0; ir = 1'b0;

        //            rst fl fpc           fv fd             rdy chk fr v  instr          pc        c
        vecs.push_back(mk(1, 0, 32'h0,       0, 32'h0,          0, 0, 0, 0, 32'h0,          32'h0,    0));
        vecs.push_back(mk(0, 0, 32'h0,       0, 32'h0,          0, 1, 1, 0, 32'h0,          RP,       0));
        vecs.push_back(mk(0, 0, 32'h0,       1, 32'h0000_0013,  1, 1, 1, 0, 32'h0,          RP,       0));
        vecs.push_back(mk(0, 0, 32'h0,       0, 32'h0,          1, 1, 1, 1, 32'h0000_0013,  RP,       0));
        vecs.push_back(mk(0, 0, 32'h0,       0, 32'h0,          0, 1, 1, 0, 32'h0,          RP+4,     0));
        // back-to-back push and pop
        vecs.push_back(mk(0, 0, 32'h0,       1, 32'h1111_1113,  1, 1, 1, 0, 32'h0,          RP+4,     0));
        vecs.push_back(mk(0, 0, 32'h0,       1, 32'h2222_2223,  1, 1, 1, 1, 32'h1111_1113,  RP+4,     0));
        vecs.push_back(mk(0, 0, 32'h0,       0, 32'h0,          1, 1, 1, 1, 32'h2222_2223,  RP+8,     0));
        // fill to full, hold fifth word, release with one pop
        vecs.push_back(mk(0, 0, 32'h0,       1, 32'hA0A0_A0A3,  0, 1, 1, 0, 32'h0,          RP+12,    0));
        vecs.push_back(mk(0, 0, 32'h0,       1, 32'hB0B0_B0B3,  0, 1, 1, 1, 32'hA0A0_A0A3,  RP+12,    0));
        vecs.push_back(mk(0, 0, 32'h0,       1, 32'hC0C0_C0C3,  0, 1, 1, 1, 32'hA0A0_A0A3,  RP+12,    0));
        vecs.push_back(mk(0, 0, 32'h0,       1, 32'hD0D0_D0D3,  0, 1, 1, 1, 32'hA0A0_A0A3,  RP+12,    0));
        vecs.push_back(mk(0, 0, 32'h0,       1, 32'hE0E0_E0E3,  0, 1, 0, 1, 32'hA0A0_A0A3,  RP+12,    0));
        vecs.push_back(mk(0, 0, 32'h0,       1, 32'hE0E0_E0E3,  1, 1, 0, 1, 32'hA0A0_A0A3,  RP+12,    0));
        vecs.push_back(mk(0, 0, 32'h0,       1, 32'hE0E0_E0E3,  0, 1, 1, 1, 32'hB0B0_B0B3,  RP+16,    0));
        vecs.push_back(mk(0, 0, 32'h0,       0, 32'h0,          1, 1, 0, 1, 32'hB0B0_B0B3,  RP+16,    0));
        vecs.push_back(mk(0, 0, 32'h0,       0, 32'h0,          1, 1, 1, 1, 32'hC0C0_C0C3,  RP+20,    0));
        vecs.push_back(mk(0, 0, 32'h0,       0, 32'h0,          1, 1, 1, 1, 32'hD0D0_D0D3,  RP+24,    0));
        vecs.push_back(mk(0, 0, 32'h0,       0, 32'h0,          1, 1, 1, 1, 32'hE0E0_E0E3,  RP+28,    0));
        // redirect while data is buffered and a word is offered
        vecs.push_back(mk(0, 0, 32'h0,       1, 32'h1234_5673,  0, 1, 1, 0, 32'h0,          RP+32,    0));
        vecs.push_back(mk(0, 1, 32'h102,     1, 32'hAAAA_4505,  1, 1, 0, 0, 32'h0,          RP+32,    0));
        vecs.push_back(mk(0, 0, 32'h0,       1, 32'hAAAA_4505,  1, 1, 1, 0, 32'h0,          FL1_PC,   0));
        vecs.push_back(mk(0, 0, 32'h0,       0, 32'h0,          1, 1, 1, 1, G_INSTR,        FL1_PC,   G_C));
        // reset with six halfwords buffered and a word pending
        vecs.push_back(mk(0, 0, 32'h0,       1, 32'h0001_1113,  0, 1, 1, 0, 32'h0,          32'h104,  0));
        vecs.push_back(mk(0, 0, 32'h0,       1, 32'h0002_2223,  0, 1, 1, 1, 32'h0001_1113,  32'h104,  0));
        vecs.push_back(mk(0, 0, 32'h0,       1, 32'h0003_3333,  0, 1, 1, 1, 32'h0001_1113,  32'h104,  0));
        vecs.push_back(mk(1, 0, 32'h0,       1, 32'hDEAD_0003,  1, 1, 1, 1, 32'h0001_1113,  32'h104,  0));
        vecs.push_back(mk(0, 0, 32'h0,       0, 32'h0,          1, 1, 1, 0, 32'h0,          RP,       0));
        vecs.push_back(mk(0, 0, 32'h0,       1, 32'h3333_3333,  0, 1, 1, 0, 32'h0,          RP,       0));
        vecs.push_back(mk(0, 0, 32'h0,       0, 32'h0,          1, 1, 1, 1, 32'h3333_3333,  RP,       0));
        // redirect to an odd address: bit 0 (and bit 1 without RVC) dropped
        vecs.push_back(mk(0, 1, 32'h207,     0, 32'h0,          1, 1, 0, 0, 32'h0,          RP+4,     0));
        vecs.push_back(mk(0, 0, 32'h0,       0, 32'h0,          1, 1, 1, 0, 32'h0,          FL2_PC,   0));

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].fl, vecs[i].fpc, vecs[i].fv, vecs[i].fd, vecs[i].rdy);
            if (vecs[i].chk) begin
                check_all($sformatf("v%0d", i), vecs[i].e_fr, vecs[i].e_v,
                          vecs[i].e_instr, vecs[i].e_pc, vecs[i].e_c);
            end
        end

        // Single-word latency after reset: valid on the cycle after the push.
        step(1, 0, 32'h0, 0, 32'h0, 0);
        step(0, 0, 32'h0, 1, 32'hDEAD_BEE3, 0);
        check_all("lat0", 1, 0, 32'h0, RP, 0);
        step(0, 0, 32'h0, 0, 32'h0, 0);
        wait_valid(4, "lat1.wait");
        check_all("lat1", 1, 1, 32'hDEAD_BEE3, RP, 0);
        // Flush beats a simultaneous pop: PC follows the redirect, not the pop.
        step(0, 1, 32'h0000_0300, 0, 32'h0, 1);
        check_all("fpop0", 0, 0, 32'h0, RP, 0);
        step(0, 0, 32'h0, 0, 32'h0, 1);
        check_all("fpop1", 1, 0, 32'h0, 32'h300, 0);

`ifdef FETCH_ALIGN_RVC_EN
        // Two compressed instructions from one word, consecutive cycles.
        step(1, 0, 32'h0, 0, 32'h0, 0);
        step(0, 0, 32'h0, 1, 32'h4501_4505, 1);
        check_all("rvc0", 1, 0, 32'h0, RP, 0);
        step(0, 0, 32'h0, 0, 32'h0, 1);
        check_all("rvc1", 1, 1, 32'h0000_4505, RP, 1);
        step(0, 0, 32'h0, 0, 32'h0, 1);
        check_all("rvc2", 1, 1, 32'h0000_4501, RP+2, 1);
        step(0, 0, 32'h0, 0, 32'h0, 1);
        check_all("rvc3", 1, 0, 32'h0, RP+4, 0);
        // 32-bit instruction straddling two fetch words, with a stall between them.
        step(0, 0, 32'h0, 1, 32'h0093_4505, 1);
        check_all("str0", 1, 0, 32'h0, RP+4, 0);
        step(0, 0, 32'h0, 0, 32'h0, 1);
        check_all("str1", 1, 1, 32'h0000_4505, RP+4, 1);
        step(0, 0, 32'h0, 0, 32'h0, 1);
        check_all("str2", 1, 0, 32'h0, RP+6, 0);
        step(0, 0, 32'h0, 1, 32'h4501_0050, 1);
        check_all("str3", 1, 0, 32'h0, RP+6, 0);
        step(0, 0, 32'h0, 0, 32'h0, 1);
        check_all("str4", 1, 1, 32'h0050_0093, RP+6, 0);
        step(0, 0, 32'h0, 0, 32'h0, 1);
        check_all("str5", 1, 1, 32'h0000_4501, RP+10, 1);
        step(0, 0, 32'h0, 0, 32'h0, 1);
        check_all("str6", 1, 0, 32'h0, RP+12, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
